// File: rtl/aes_pkg.sv
// AES shared types and GF(2^8) helpers.
// Used by both cipher directions.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // byte r+4c of the state is row r, column c
  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c-r)&3)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
       ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
       ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
       ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
       ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/dec_round.sv
// One combinational AES inverse round.
// is_final drops InvMixColumns for the last round.
module dec_round
  import aes_pkg::*;
(
  input  logic [127:0] din,
  input  logic [127:0] rkey,
  input  logic         is_final,
  output logic [127:0] dout
);

  logic [127:0] sr;
  logic [127:0] sb;
  logic [127:0] ak;
  logic [127:0] mc;

  always_comb begin
    sb = '0;
    mc = '0;
    sr = inv_shift_rows(din);
    for (int i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = inv_sbox(sr[127-8*i -: 8]);
    end
    ak = sb ^ rkey;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = inv_mix_col(ak[127-32*c -: 32]);
    end
  end

  assign dout = is_final ? ak : mc;

endmodule

// File: rtl/dec_core.sv
// Iterative AES-128 inverse cipher, one round per cycle.
// Round keys come from the external key store by index.
module dec_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic [3:0]   rkey_idx,
  input  logic [127:0] rkey,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);

  state_t       state;
  logic [127:0] st;
  logic [127:0] nxt;
  logic [3:0]   rnd;

  dec_round u_round (
    .din      (st),
    .rkey     (rkey),
    .is_final (rnd == 4'd0),
    .dout     (nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      st    <= '0;
      rnd   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= din ^ rkey;
            rnd   <= 4'(NR - 1);
            state <= ROUND;
          end
        end
        ROUND: begin
          st <= nxt;
          if (rnd == 4'd0) state <= DONE;
          else rnd <= rnd - 4'd1;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // all outputs decode registered state only
  always_comb begin
    rkey_idx = 4'(NR);
    unique case (state)
      IDLE:    rkey_idx = 4'(NR);
      ROUND:   rkey_idx = rnd;
      DONE:    rkey_idx = 4'd0;
      default: rkey_idx = 4'(NR);
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dout      = st;

endmodule

// File: tb/tb_dec_core.sv
// Bench for dec_core: known vectors, handshake timing,
// reset, and random blocks against a forward-cipher model.
module tb_dec_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] din = '0;
  logic [3:0]   rkey_idx;
  logic [127:0] rkey;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] dout;
  logic         busy;

  logic [127:0] rk [0:10];
  logic [7:0]   sbox_t [0:255];
  int errors = 0;
  int checks = 0;

  dec_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .rkey_idx  (rkey_idx),
    .rkey      (rkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // key store: same-cycle lookup
  always_comb begin
    rkey = '0;
    if (rkey_idx <= 4'd10) rkey = rk[rkey_idx];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b,
                                       input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  // S-box from its definition: GF inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s,
                                    input int i);
    return s[127-8*i -: 8];
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]],
             sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // forward cipher with the currently loaded keys
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] t;
    logic [7:0]   k [0:3];
    logic [7:0]   b;
    k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++)
        s[127-8*i -: 8] = sbox_t[gb(s, i)];
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[127-8*(w+4*c) -: 8] = gb(s, w + 4*((c+w)%4));
      s = t;
      if (r < 10) begin
        t = '0;
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++)
              b = b ^ gmul(k[(j-i)&3], gb(s, j + 4*c));
            t[127-8*(i+4*c) -: 8] = b;
          end
        s = t;
      end
      s = s ^ rk[r];
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // accept one block, check latency, key index walk and result
  task automatic run_block(input logic [127:0] ct,
                           input logic [127:0] pt,
                           input string tag);
    din = ct;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check({tag, "_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_idx10"}, 128'(rkey_idx), 128'(10));
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s_idx%0d", tag, 9 - k),
            128'(rkey_idx), 128'(9 - k));
      check($sformatf("%s_ov_low%0d", tag, k),
            128'(out_valid), 128'(0));
      tick();
    end
    check({tag, "_ov"}, 128'(out_valid), 128'(1));
    check({tag, "_dout"}, dout, pt);
    check({tag, "_idx_done"}, 128'(rkey_idx), 128'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 128'(in_ready), 128'(1));
    check({tag, "_ov_clr"}, 128'(out_valid), 128'(0));
  endtask

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    int n;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;

    build_sbox();
    load_key(K_C1);

    // reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_ready", 128'(in_ready), 128'(1));
    check("rst_ov", 128'(out_valid), 128'(0));
    check("rst_dout", dout, '0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_idx", 128'(rkey_idx), 128'(10));

    // known-answer vectors
    run_block(CT_C1, PT_C1, "c1");
    load_key(K_B);
    run_block(CT_B, PT_B, "appb");

    // back-to-back, both handshakes held high
    load_key(K_C1);
    din = CT_C1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      check($sformatf("b2b_ov%0d", i), 128'(out_valid),
            128'(i % 12 == 10));
      check($sformatf("b2b_ir%0d", i), 128'(in_ready),
            128'(i % 12 == 11));
      if (i % 12 == 10)
        check($sformatf("b2b_dout%0d", i), dout, PT_C1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // backpressure with ignored in_valid pulses
    din = CT_C1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_done", 128'(out_valid), 128'(1));
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      din = rnd128();
      tick();
      check($sformatf("bp_ov%0d", i), 128'(out_valid), 128'(1));
      check($sformatf("bp_dout%0d", i), dout, PT_C1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle", 128'(in_ready), 128'(1));
    tick();
    check("bp_no_accept", 128'(busy), 128'(0));

    // reset mid-round
    din = CT_C1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("mid_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_ready", 128'(in_ready), 128'(1));
    check("mid_ov", 128'(out_valid), 128'(0));
    check("mid_dout", dout, '0);
    check("mid_idx", 128'(rkey_idx), 128'(10));
    run_block(CT_C1, PT_C1, "after_rst");

    // random keys and blocks with throttling
    for (int b = 0; b < 1000; b++) begin
      key = rnd128();
      pt = rnd128();
      load_key(key);
      ct = encrypt(pt);
      repeat ($urandom_range(0, 2)) tick();
      din = ct;
      in_valid = 1'b1;
      tick();
      n = 0;
      while (!out_valid && n < 40) begin
        in_valid = 1'($urandom_range(0, 1));
        din = rnd128();
        tick();
        n++;
      end
      in_valid = 1'b0;
      check($sformatf("rnd%0d_done", b), 128'(out_valid), 128'(1));
      repeat ($urandom_range(0, 3)) tick();
      check($sformatf("rnd%0d_dout", b), dout, pt);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
